// File: rtl/pwm_pkg.sv
// Shared constants for the multi-channel PWM block.
// Mode encodings and default sizing.
package pwm_pkg;

    localparam int NCH_DEF = 4;
    localparam int W_DEF   = 8;

    typedef enum logic {
        MODE_EDGE   = 1'b0,
        MODE_CENTER = 1'b1
    } mode_e;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: duty compare, polarity and output register.
// Output follows the counter one clk later.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic [W-1:0] cnt,
    input  logic [W-1:0] duty,
    input  logic         polarity,
    output logic         pwmout
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwmout <= 1'b0;
        end else if (!enable) begin
            pwmout <= polarity;
        end else begin
            pwmout <= (cnt < duty) ^ polarity;
        end
    end

endmodule

// File: rtl/pwm_multich.sv
// Multi-channel PWM: prescaler, shared period counter,
// double-buffered mode/period/duty, NCH output channels.
module pwm_multich
    import pwm_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int W   = W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           enable,
    input  logic           mode,
    input  logic [7:0]     div,
    input  logic [W-1:0]   period,
    input  logic [NCH*W-1:0] duty,
    input  logic [NCH-1:0] polarity,
    input  logic           load,
    output logic [NCH-1:0] pwmout,
    output logic           cycle_start,
    output logic           load_ack
);

    logic [7:0]       pc;
    logic [W-1:0]     cnt;
    logic [W-1:0]     cnt_nxt;
    logic             dir;
    logic             dir_nxt;
    logic             wrap;
    logic             tick;
    logic             boundary;
    logic             pending;
    mode_e            sh_mode;
    mode_e            act_mode;
    logic [W-1:0]     sh_period;
    logic [W-1:0]     act_period;
    logic [NCH*W-1:0] sh_duty;
    logic [NCH*W-1:0] act_duty;

    assign tick     = enable && (pc == div);
    assign boundary = tick && wrap;

    // Center mode visits each value twice per period:
    // 0..P-1 going up, then P-1..0 going down (dir=1).
    always_comb begin
        cnt_nxt = cnt;
        dir_nxt = dir;
        wrap    = 1'b0;
        if (act_mode == MODE_EDGE) begin
            if (cnt >= act_period) begin
                wrap = 1'b1;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end else if (act_period == '0) begin
            wrap = 1'b1;
        end else if (!dir) begin
            if (cnt >= act_period - 1'b1) begin
                dir_nxt = 1'b1;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end else if (cnt == '0) begin
            wrap = 1'b1;
        end else begin
            cnt_nxt = cnt - 1'b1;
        end
        if (wrap) begin
            cnt_nxt = '0;
            dir_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_mode   <= MODE_EDGE;
            sh_period <= '0;
            sh_duty   <= '0;
        end else if (load) begin
            sh_mode   <= mode_e'(mode);
            sh_period <= period;
            sh_duty   <= duty;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc          <= '0;
            cnt         <= '0;
            dir         <= 1'b0;
            pending     <= 1'b0;
            cycle_start <= 1'b0;
            load_ack    <= 1'b0;
            act_mode    <= MODE_EDGE;
            act_period  <= '0;
            act_duty    <= '0;
        end else begin
            pending     <= load | (enable & pending & ~boundary);
            cycle_start <= boundary;
            load_ack    <= boundary & pending;
            if (!enable) begin
                pc         <= '0;
                cnt        <= '0;
                dir        <= 1'b0;
                act_mode   <= sh_mode;
                act_period <= sh_period;
                act_duty   <= sh_duty;
            end else begin
                pc <= tick ? 8'd0 : pc + 8'd1;
                if (tick) begin
                    cnt <= cnt_nxt;
                    dir <= dir_nxt;
                end
                if (boundary && pending) begin
                    act_mode   <= sh_mode;
                    act_period <= sh_period;
                    act_duty   <= sh_duty;
                end
            end
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        pwm_channel #(
            .W(W)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .enable  (enable),
            .cnt     (cnt),
            .duty    (act_duty[i*W +: W]),
            .polarity(polarity[i]),
            .pwmout  (pwmout[i])
        );
    end

endmodule
